// File: rtl/dec_trace_pkg.sv
// Shared types for the decoder trace capture unit: instruction classes, trace record layout
// and the priority classifier.
package dec_trace_pkg;

   typedef enum logic [3:0] {
      ClsAlu     = 4'd0,
      ClsIllegal = 4'd1,
      ClsEbrk    = 4'd2,
      ClsEcall   = 4'd3,
      ClsMret    = 4'd4,
      ClsDret    = 4'd5,
      ClsWfi     = 4'd6,
      ClsJump    = 4'd7,
      ClsBranch  = 4'd8,
      ClsLoad    = 4'd9,
      ClsStore   = 4'd10,
      ClsMult    = 4'd11,
      ClsDiv     = 4'd12,
      ClsCsr     = 4'd13
   } cls_e;

   typedef struct packed {
      cls_e        cls;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] instr;
   } trace_rec_t;

   typedef struct packed {
      logic illegal;
      logic ebrk;
      logic ecall;
      logic mret;
      logic dret;
      logic wfi;
      logic jump;
      logic branch;
      logic data_req;
      logic data_we;
      logic mult_en;
      logic div_en;
      logic csr_access;
   } dec_flags_t;

   localparam int unsigned REC_W   = $bits(trace_rec_t);
   localparam int unsigned NUM_CLS = 14;

   // First matching flag wins; an instruction with no flags set is plain ALU.
   function automatic cls_e classify(input dec_flags_t f);
      cls_e c;
      if (f.illegal)                    c = ClsIllegal;
      else if (f.ebrk)                  c = ClsEbrk;
      else if (f.ecall)                 c = ClsEcall;
      else if (f.mret)                  c = ClsMret;
      else if (f.dret)                  c = ClsDret;
      else if (f.wfi)                   c = ClsWfi;
      else if (f.jump)                  c = ClsJump;
      else if (f.branch)                c = ClsBranch;
      else if (f.data_req && !f.data_we) c = ClsLoad;
      else if (f.data_req && f.data_we)  c = ClsStore;
      else if (f.mult_en)               c = ClsMult;
      else if (f.div_en)                c = ClsDiv;
      else if (f.csr_access)            c = ClsCsr;
      else                              c = ClsAlu;
      return c;
   endfunction

endpackage

// File: rtl/dec_trace_fifo.sv
// Synchronous FIFO with ready/valid pop; pointers carry an extra wrap bit to tell full from
// empty. A write while full is accepted only when a pop happens in the same cycle.
module dec_trace_fifo #(
   parameter int unsigned WIDTH = 42,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             full_o,
   output logic             rd_valid_o,
   input  logic             rd_ready_i,
   output logic [WIDTH-1:0] rd_data_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             empty;
   logic             pop;
   logic             wr_en;

   assign empty      = (wptr == rptr);
   assign full_o     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign pop        = !empty && rd_ready_i;
   assign wr_en      = push_i && (!full_o || pop);
   assign rd_valid_o = !empty;
   assign rd_data_o  = empty ? '0 : mem[rptr[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en) wptr <= wptr + (AW+1)'(1);
         if (pop)   rptr <= rptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wptr[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/dec_trace_capture.sv
// Decoder trace capture: classifies decoded instructions, counts per class and buffers records.
// Define DEC_TRACE_FILTER_EN to add class_mask_i, which keeps masked classes out of the FIFO.
module dec_trace_capture
   import dec_trace_pkg::*;
#(
   parameter int unsigned NUM_TRANS = 10,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             arm_i,
   input  logic             clear_i,
   input  logic             ev_valid_i,
   input  logic [31:0]      instr_i,
   input  logic             illegal_i,
   input  logic             ebrk_i,
   input  logic             ecall_i,
   input  logic             mret_i,
   input  logic             dret_i,
   input  logic             wfi_i,
   input  logic             jump_i,
   input  logic             branch_i,
   input  logic             data_req_i,
   input  logic             data_we_i,
   input  logic             mult_en_i,
   input  logic             div_en_i,
   input  logic             csr_access_i,
   input  logic             rf_we_i,
   input  logic [4:0]       rf_waddr_i,
`ifdef DEC_TRACE_FILTER_EN
   input  logic [15:0]      class_mask_i,
`endif
   output logic             rd_valid_o,
   input  logic             rd_ready_i,
   output logic [REC_W-1:0] rd_data_o,
   input  logic [3:0]       cnt_sel_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic [CNT_W-1:0] trans_cnt_o,
   output logic [CNT_W-1:0] drop_cnt_o,
   output logic             overflow_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

   localparam logic [CNT_W-1:0] CntMax = '1;

   state_e           state;
   dec_flags_t       flags;
   cls_e             cls;
   logic [3:0]       cls_idx;
   trace_rec_t       rec;
   logic             sample;
   logic             pass;
   logic             push;
   logic             pop;
   logic             drop;
   logic             fifo_full;
   logic             fifo_rst;
   logic             hit_limit;
   logic [CNT_W-1:0] trans_next;
   logic [CNT_W-1:0] sel_val;
   logic [CNT_W-1:0] cls_cnt [NUM_CLS];

   always_comb begin
      flags            = '0;
      flags.illegal    = illegal_i;
      flags.ebrk       = ebrk_i;
      flags.ecall      = ecall_i;
      flags.mret       = mret_i;
      flags.dret       = dret_i;
      flags.wfi        = wfi_i;
      flags.jump       = jump_i;
      flags.branch     = branch_i;
      flags.data_req   = data_req_i;
      flags.data_we    = data_we_i;
      flags.mult_en    = mult_en_i;
      flags.div_en     = div_en_i;
      flags.csr_access = csr_access_i;
   end

   assign cls     = classify(flags);
   assign cls_idx = cls;

   always_comb begin
      rec          = '0;
      rec.cls      = cls;
      rec.rf_we    = rf_we_i;
      rec.rf_waddr = rf_waddr_i;
      rec.instr    = instr_i;
   end

`ifdef DEC_TRACE_FILTER_EN
   assign pass = class_mask_i[cls_idx];
`else
   assign pass = 1'b1;
`endif

   assign sample     = (state == StCapture) && ev_valid_i;
   assign push       = sample && pass;
   assign pop        = rd_valid_o && rd_ready_i;
   // A pop in the same cycle frees the slot, so only an unmatched push into a full FIFO drops.
   assign drop       = push && fifo_full && !pop;
   assign fifo_rst   = rst_i || clear_i;
   assign trans_next = (trans_cnt_o == CntMax) ? trans_cnt_o : trans_cnt_o + CNT_W'(1);
   assign hit_limit  = (NUM_TRANS != 0) && push && (32'(trans_next) == NUM_TRANS);

   dec_trace_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (fifo_rst),
      .push_i     (push),
      .wdata_i    (rec),
      .full_o     (fifo_full),
      .rd_valid_o (rd_valid_o),
      .rd_ready_i (rd_ready_i),
      .rd_data_o  (rd_data_o)
   );

   // Capture FSM; trans_cnt restarts on every arm so a re-armed run gets a fresh limit.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state       <= StIdle;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         trans_cnt_o <= '0;
      end else begin
         case (state)
            StIdle, StDone: begin
               if (arm_i) begin
                  state       <= StCapture;
                  busy_o      <= 1'b1;
                  done_o      <= 1'b0;
                  trans_cnt_o <= '0;
               end
            end
            StCapture: begin
               if (push) trans_cnt_o <= trans_next;
               if (hit_limit) begin
                  state  <= StDone;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end
            end
            default: begin
               state  <= StIdle;
               busy_o <= 1'b0;
               done_o <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         drop_cnt_o <= '0;
         overflow_o <= 1'b0;
         for (int i = 0; i < int'(NUM_CLS); i++) cls_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_CLS); i++) begin
            if (sample && (cls_idx == 4'(i)) && (cls_cnt[i] != CntMax)) begin
               cls_cnt[i] <= cls_cnt[i] + CNT_W'(1);
            end
         end
         if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != CntMax) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
         end
      end
   end

   // Codes 14 and 15 have no counter and read back as zero.
   always_comb begin
      sel_val = '0;
      for (int i = 0; i < int'(NUM_CLS); i++) begin
         if (cnt_sel_i == 4'(i)) sel_val = cls_cnt[i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) cnt_o <= '0;
      else                  cnt_o <= sel_val;
   end

endmodule

// File: tb/tb_dec_trace_capture.sv
// Scoreboard bench for dec_trace_capture: expected records are queued at issue time and a
// negedge monitor checks every record the DUT hands out.
module tb_dec_trace_capture;
   import dec_trace_pkg::*;

   localparam logic [12:0] FIll = 13'h0001;
   localparam logic [12:0] FJmp = 13'h0040;
   localparam logic [12:0] FReq = 13'h0100;
   localparam logic [12:0] FWe  = 13'h0200;
   localparam logic [12:0] FMul = 13'h0400;
   localparam logic [12:0] FCsr = 13'h1000;

   logic        clk = 1'b0;
   logic        rst, arm, clear, ev_valid, rf_we, rd_ready;
   logic [31:0] instr;
   logic [12:0] flg;
   logic [4:0]  rf_waddr;
   logic [3:0]  cnt_sel;
   logic [15:0] mask;
   logic        rd_valid, overflow, busy, done;
   logic [41:0] rd_data;
   logic [15:0] cnt, trans, drop;

   logic        s_arm, s_ev_valid, s_rd_ready;
   logic [3:0]  s_cnt_sel;
   logic [15:0] s_mask;
   logic        s_rd_valid, s_overflow, s_busy, s_done;
   logic [41:0] s_rd_data;
   logic [3:0]  s_cnt, s_trans, s_drop;

   int          vectors = 0;
   int          miscompares = 0;
   int          pops = 0;
   int          base;
   logic [41:0] exp_q[$];
   logic [41:0] mon_exp;

   always #5 clk = ~clk;

   dec_trace_capture #(.NUM_TRANS(10), .DEPTH(8), .CNT_W(16)) u_dut (
      .clk_i(clk), .rst_i(rst), .arm_i(arm), .clear_i(clear), .ev_valid_i(ev_valid),
      .instr_i(instr), .illegal_i(flg[0]), .ebrk_i(flg[1]), .ecall_i(flg[2]), .mret_i(flg[3]),
      .dret_i(flg[4]), .wfi_i(flg[5]), .jump_i(flg[6]), .branch_i(flg[7]),
      .data_req_i(flg[8]), .data_we_i(flg[9]), .mult_en_i(flg[10]), .div_en_i(flg[11]),
      .csr_access_i(flg[12]), .rf_we_i(rf_we), .rf_waddr_i(rf_waddr),
`ifdef DEC_TRACE_FILTER_EN
      .class_mask_i(mask),
`endif
      .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data), .cnt_sel_i(cnt_sel),
      .cnt_o(cnt), .trans_cnt_o(trans), .drop_cnt_o(drop), .overflow_o(overflow),
      .busy_o(busy), .done_o(done)
   );

   dec_trace_capture #(.NUM_TRANS(0), .DEPTH(8), .CNT_W(4)) u_sat (
      .clk_i(clk), .rst_i(rst), .arm_i(s_arm), .clear_i(1'b0), .ev_valid_i(s_ev_valid),
      .instr_i(instr), .illegal_i(flg[0]), .ebrk_i(flg[1]), .ecall_i(flg[2]), .mret_i(flg[3]),
      .dret_i(flg[4]), .wfi_i(flg[5]), .jump_i(flg[6]), .branch_i(flg[7]),
      .data_req_i(flg[8]), .data_we_i(flg[9]), .mult_en_i(flg[10]), .div_en_i(flg[11]),
      .csr_access_i(flg[12]), .rf_we_i(rf_we), .rf_waddr_i(rf_waddr),
`ifdef DEC_TRACE_FILTER_EN
      .class_mask_i(s_mask),
`endif
      .rd_valid_o(s_rd_valid), .rd_ready_i(s_rd_ready), .rd_data_o(s_rd_data),
      .cnt_sel_i(s_cnt_sel), .cnt_o(s_cnt), .trans_cnt_o(s_trans), .drop_cnt_o(s_drop),
      .overflow_o(s_overflow), .busy_o(s_busy), .done_o(s_done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic ev(input logic [12:0] f, input logic [31:0] ins, input logic we,
                     input logic [4:0] wa, input logic [3:0] cls, input bit stored);
      ev_valid = 1'b1;
      flg      = f;
      instr    = ins;
      rf_we    = we;
      rf_waddr = wa;
      if (stored) exp_q.push_back({cls, we, wa, ins});
      step();
      ev_valid = 1'b0;
      flg      = '0;
   endtask

   task automatic check_cnt(input logic [3:0] sel, input logic [15:0] exp, input string name);
      cnt_sel = sel;
      step();
      check(name, cnt, exp);
   endtask

   // Monitor: a handshake seen at negedge completes on the next posedge.
   always @(negedge clk) begin
      if (!rst && !clear && rd_valid && rd_ready) begin
         vectors++;
         pops++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL rd_data: got unexpected record %h, expected none", rd_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (rd_data !== mon_exp) begin
               miscompares++;
               $display("FAIL rd_data: got %h, expected %h", rd_data, mon_exp);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; arm = 1'b0; clear = 1'b0; ev_valid = 1'b0; flg = '0; instr = '0;
      rf_we = 1'b0; rf_waddr = '0; rd_ready = 1'b1; cnt_sel = '0; mask = 16'hffff;
      s_arm = 1'b0; s_ev_valid = 1'b0; s_rd_ready = 1'b0; s_cnt_sel = '0; s_mask = 16'hffff;
      repeat (2) step();
      rst = 1'b0;
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_trans", trans, 0);
      check("rst_drop", drop, 0);
      check("rst_overflow", overflow, 0);
      check("rst_cnt", cnt, 0);

      // Three ALU instructions
      arm = 1'b1; step(); arm = 1'b0;
      check("arm_busy", busy, 1);
      ev(13'h0, 32'h00b50533, 1'b1, 5'd10, 4'd0, 1'b1);
      ev(13'h0, 32'h00c58633, 1'b1, 5'd12, 4'd0, 1'b1);
      ev(13'h0, 32'h00d60733, 1'b1, 5'd14, 4'd0, 1'b1);
      repeat (2) step();
      check_cnt(4'd0, 16'd3, "cnt_alu_3");
      check("trans_3", trans, 3);
      check("drain_a", exp_q.size(), 0);

      // Priority classes, then the 10-event limit
      ev(FIll | FJmp | FReq, 32'hffffffff, 1'b0, 5'd0, 4'd1, 1'b1);
      ev(FReq, 32'h0004a503, 1'b1, 5'd10, 4'd9, 1'b1);
      ev(FReq | FWe, 32'h00a4a023, 1'b0, 5'd0, 4'd10, 1'b1);
      ev(FMul, 32'h02b50533, 1'b1, 5'd10, 4'd11, 1'b1);
      ev(FCsr, 32'h30002573, 1'b1, 5'd10, 4'd13, 1'b1);
      ev(13'h0, 32'h00100093, 1'b1, 5'd1, 4'd0, 1'b1);
      check("done_before_limit", done, 0);
      ev(13'h0, 32'h00200113, 1'b1, 5'd2, 4'd0, 1'b1);
      check("done_at_limit", done, 1);
      check("busy_at_limit", busy, 0);
      ev(13'h0, 32'h00300193, 1'b1, 5'd3, 4'd0, 1'b0);
      ev(13'h0, 32'h00400213, 1'b1, 5'd4, 4'd0, 1'b0);
      repeat (2) step();
      check("trans_10", trans, 10);
      check_cnt(4'd0, 16'd5, "cnt_alu_5");
      check_cnt(4'd1, 16'd1, "cnt_illegal");
      check_cnt(4'd7, 16'd0, "cnt_jump");
      check_cnt(4'd9, 16'd1, "cnt_load");
      check_cnt(4'd10, 16'd1, "cnt_store");
      check_cnt(4'd13, 16'd1, "cnt_csr");
      check_cnt(4'd14, 16'd0, "cnt_unused");
      check("drain_b", exp_q.size(), 0);

      // Re-arm from DONE with reads stalled: overflow
      arm = 1'b1; step(); arm = 1'b0;
      check("rearm_busy", busy, 1);
      check("rearm_trans", trans, 0);
      rd_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ev(13'h0, 32'h10000000 + 32'(i), 1'(i & 1), 5'(i), 4'd0, i < 8);
      end
      check("ovf_drop", drop, 2);
      check("ovf_flag", overflow, 1);
      check("ovf_trans", trans, 10);
      check("ovf_done", done, 1);
      check("ovf_rd_valid", rd_valid, 1);
      check("stall_head", rd_data, exp_q[0]);
      repeat (3) step();
      check("stall_hold", rd_data, exp_q[0]);
      rd_ready = 1'b1;
      repeat (10) step();
      check("drain_c", exp_q.size(), 0);
      check("drain_c_valid", rd_valid, 0);
      check_cnt(4'd0, 16'd15, "cnt_alu_15");

      // Clear dominates arm and events
      clear = 1'b1; arm = 1'b1; ev_valid = 1'b1;
      step();
      clear = 1'b0; arm = 1'b0; ev_valid = 1'b0;
      check("clr_busy", busy, 0);
      check("clr_done", done, 0);
      check("clr_trans", trans, 0);
      check("clr_drop", drop, 0);
      check("clr_overflow", overflow, 0);
      check("clr_cnt_o", cnt, 0);
      check_cnt(4'd0, 16'd0, "clr_cnt_alu");

      // Full FIFO with push and pop in the same cycle
      arm = 1'b1; step(); arm = 1'b0;
      rd_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ev(13'h0, 32'h20000000 + 32'(i), 1'b1, 5'(i), 4'd0, 1'b1);
      end
      check("full_rd_valid", rd_valid, 1);
      rd_ready = 1'b1;
      ev(13'h0, 32'h20000008, 1'b1, 5'd8, 4'd0, 1'b1);
      rd_ready = 1'b0;
      check("pp_drop", drop, 0);
      check("pp_overflow", overflow, 0);
      check("pp_trans", trans, 9);
      check("pp_busy", busy, 1);
      base = pops;
      rd_ready = 1'b1;
      repeat (12) step();
      check("pp_count", pops - base, 8);
      check("drain_e", exp_q.size(), 0);

      // CNT_W=4 instance, unlimited run, reads stalled
      s_arm = 1'b1; step(); s_arm = 1'b0;
      for (int i = 0; i < 20; i++) begin
         s_ev_valid = 1'b1; instr = 32'h30000000 + 32'(i); rf_we = 1'b0; rf_waddr = '0;
         step();
         s_ev_valid = 1'b0;
      end
      step();
      check("sat_cnt_alu", s_cnt, 4'hf);
      check("sat_trans", s_trans, 4'hf);
      check("sat_drop", s_drop, 4'd12);
      check("sat_overflow", s_overflow, 1);
      check("sat_busy", s_busy, 1);
      check("sat_done", s_done, 0);
      check("sat_head", s_rd_data, {4'h0, 1'b0, 5'd0, 32'h30000000});

`ifdef DEC_TRACE_FILTER_EN
      clear = 1'b1; step(); clear = 1'b0;
      mask = 16'h0001;
      arm = 1'b1; step(); arm = 1'b0;
      ev(FReq, 32'h0004a503, 1'b1, 5'd10, 4'd9, 1'b0);
      ev(13'h0, 32'h00000013, 1'b0, 5'd0, 4'd0, 1'b1);
      repeat (2) step();
      check_cnt(4'd9, 16'd1, "flt_cnt_load");
      check("flt_trans", trans, 1);
      check("flt_drop", drop, 0);
      check("drain_f", exp_q.size(), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
